// File: rtl/char_menu_16x2_select_if.sv
// Bus between the difficulty-screen menu and its driver: character address,
// button pulses in; character code and level selection out.
interface char_menu_16x2_select_if;
    logic [7:0] char_xy;
    logic       btn_up;
    logic       btn_dn;
    logic       confirm;
    logic       unlock;
    logic [6:0] char_code;
    logic [1:0] level;
    logic       locked;

    modport master (
        output char_xy, btn_up, btn_dn, confirm, unlock,
        input  char_code, level, locked
    );

    modport slave (
        input  char_xy, btn_up, btn_dn, confirm, unlock,
        output char_code, level, locked
    );
endinterface

// File: rtl/char_menu_16x2_select.sv
// Level-select menu for the 16x2 pre-game overlay: owns the selected level,
// the confirm/lock state and the blinking name field, and feeds the font ROM.
module char_menu_16x2_select #(
    parameter int NUM_LEVELS    = 3,
    parameter int DEFAULT_LEVEL = 0,
    parameter int BLINK_BITS    = 24
) (
    input logic                     clk,
    input logic                     reset,
    char_menu_16x2_select_if.slave  bus
);

    localparam logic [6:0] BLANK      = 7'h20;
    localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [1:0] RESET_LVL  = 2'(DEFAULT_LEVEL);

    typedef enum logic {
        SELECT,
        LOCKED
    } lock_state_t;

    lock_state_t           state_q, state_d;
    logic [1:0]            level_q, level_d;
    logic [BLINK_BITS-1:0] blink_q;
    logic [6:0]            char_q, char_d;
    logic                  locked;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SELECT;
            level_q <= RESET_LVL;
            blink_q <= '0;
            char_q  <= BLANK;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            blink_q <= blink_q + BLINK_BITS'(1);
            char_q  <= char_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SELECT:  if (bus.confirm && !bus.unlock) state_d = LOCKED;
            LOCKED:  if (bus.unlock && !bus.confirm) state_d = SELECT;
            default: state_d = SELECT;
        endcase
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    // Stepping is gated by the current state only, so a step coinciding with
    // confirm still lands and becomes the locked value.
    always_comb begin
        level_d = level_q;
        if (!locked) begin
            if (bus.btn_up && !bus.btn_dn)
                level_d = (level_q == LAST_LEVEL) ? 2'd0 : level_q + 2'd1;
            else if (bus.btn_dn && !bus.btn_up)
                level_d = (level_q == 2'd0) ? LAST_LEVEL : level_q - 2'd1;
        end
    end

    function automatic logic [6:0] title_char(input logic [3:0] col);
        case (col)
            4'h3:    title_char = 7'h44;
            4'h4:    title_char = 7'h49;
            4'h5:    title_char = 7'h46;
            4'h6:    title_char = 7'h46;
            4'h7:    title_char = 7'h49;
            4'h8:    title_char = 7'h43;
            4'h9:    title_char = 7'h55;
            4'ha:    title_char = 7'h4c;
            4'hb:    title_char = 7'h54;
            4'hc:    title_char = 7'h59;
            4'hd:    title_char = 7'h3a;
            default: title_char = BLANK;
        endcase
    endfunction

    function automatic logic [6:0] name_char(input logic [1:0] lvl, input logic [3:0] idx);
        name_char = BLANK;
        case (lvl)
            2'd0: case (idx)
                4'd1: name_char = 7'h45;
                4'd2: name_char = 7'h41;
                4'd3: name_char = 7'h53;
                4'd4: name_char = 7'h59;
                default: name_char = BLANK;
            endcase
            2'd1: case (idx)
                4'd0: name_char = 7'h4e;
                4'd1: name_char = 7'h4f;
                4'd2: name_char = 7'h52;
                4'd3: name_char = 7'h4d;
                4'd4: name_char = 7'h41;
                4'd5: name_char = 7'h4c;
                default: name_char = BLANK;
            endcase
            2'd2: case (idx)
                4'd1: name_char = 7'h48;
                4'd2: name_char = 7'h41;
                4'd3: name_char = 7'h52;
                4'd4: name_char = 7'h44;
                default: name_char = BLANK;
            endcase
            default: case (idx)
                4'd0: name_char = 7'h45;
                4'd1: name_char = 7'h58;
                4'd2: name_char = 7'h50;
                4'd3: name_char = 7'h45;
                4'd4: name_char = 7'h52;
                4'd5: name_char = 7'h54;
                default: name_char = BLANK;
            endcase
        endcase
    endfunction

    // Out-of-range levels fall through to BLANK rather than aliasing a name.
    always_comb begin
        logic [3:0] col;
        logic       show_name;
        col       = bus.char_xy[3:0];
        show_name = locked || !blink_q[BLINK_BITS-1];
        char_d    = BLANK;
        if (bus.char_xy[7:5] == 3'b000) begin
            if (!bus.char_xy[4])
                char_d = title_char(col);
            else if (col >= 4'h5 && col <= 4'ha && show_name &&
                     int'(level_q) < NUM_LEVELS)
                char_d = name_char(level_q, col - 4'h5);
        end
    end

    assign bus.char_code = char_q;
    assign bus.level     = level_q;
    assign bus.locked    = locked;

endmodule

// File: tb/tb_char_menu_16x2_select.sv
// Bench for char_menu_16x2_select: two instances (3 and 4 levels) checked
// every cycle against a string-based model plus hand-computed expectations.
module tb_char_menu_16x2_select;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   model_valid;

    char_menu_16x2_select_if ifa ();
    char_menu_16x2_select_if ifb ();

    char_menu_16x2_select #(.NUM_LEVELS(3), .DEFAULT_LEVEL(0), .BLINK_BITS(4)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    char_menu_16x2_select #(.NUM_LEVELS(4), .DEFAULT_LEVEL(0), .BLINK_BITS(4)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state per instance: index 0 = dut_a, 1 = dut_b.
    int         nlev [2] = '{3, 4};
    int         m_level [2];
    bit         m_locked [2];
    int         m_cnt [2];
    logic [6:0] m_code [2];

    string row0 = "   DIFFICULTY:  ";
    string names [4] = '{" EASY ", "NORMAL", " HARD ", "EXPERT"};

    function automatic logic [6:0] model_char(int lvl, int n, bit lk, int cnt, logic [7:0] xy);
        int    col;
        string nm;
        col = int'(xy[3:0]);
        if (xy >= 8'h20) return 7'h20;
        if (xy[4] == 1'b0) return 7'(row0[col]);
        if (col < 5 || col > 10) return 7'h20;
        if (!lk && cnt >= 8) return 7'h20;
        if (lvl >= n) return 7'h20;
        nm = names[lvl];
        return 7'(nm[col-5]);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [7:0] xy;
            bit up, dn, cf, ul;
            int nl;
            bit nk;
            xy = (d == 0) ? ifa.char_xy : ifb.char_xy;
            up = (d == 0) ? ifa.btn_up  : ifb.btn_up;
            dn = (d == 0) ? ifa.btn_dn  : ifb.btn_dn;
            cf = (d == 0) ? ifa.confirm : ifb.confirm;
            ul = (d == 0) ? ifa.unlock  : ifb.unlock;
            if (reset) begin
                m_level[d]  <= 0;
                m_locked[d] <= 1'b0;
                m_cnt[d]    <= 0;
                m_code[d]   <= 7'h20;
            end else begin
                nl = m_level[d];
                nk = m_locked[d];
                if (!m_locked[d]) begin
                    if (up && !dn) nl = (m_level[d] + 1) % nlev[d];
                    if (dn && !up) nl = (m_level[d] + nlev[d] - 1) % nlev[d];
                    if (cf && !ul) nk = 1'b1;
                end else if (ul && !cf) begin
                    nk = 1'b0;
                end
                m_code[d]   <= model_char(m_level[d], nlev[d], m_locked[d], m_cnt[d], xy);
                m_level[d]  <= nl;
                m_locked[d] <= nk;
                m_cnt[d]    <= (m_cnt[d] + 1) % 16;
            end
        end
        if (reset) model_valid <= 1'b1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("a_code",   int'(ifa.char_code), int'(m_code[0]));
            checkOutput("a_level",  int'(ifa.level),     m_level[0]);
            checkOutput("a_locked", int'(ifa.locked),    int'(m_locked[0]));
            checkOutput("b_code",   int'(ifb.char_code), int'(m_code[1]));
            checkOutput("b_level",  int'(ifb.level),     m_level[1]);
            checkOutput("b_locked", int'(ifb.locked),    int'(m_locked[1]));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic setXy(input int d, input logic [7:0] xy);
        if (d == 0) ifa.char_xy = xy;
        else        ifb.char_xy = xy;
    endtask

    // One-cycle pulse; on return the outputs already show its effect.
    task automatic applyStimulus(input int d, input bit up, input bit dn, input bit cf, input bit ul);
        if (d == 0) begin
            ifa.btn_up = up; ifa.btn_dn = dn; ifa.confirm = cf; ifa.unlock = ul;
        end else begin
            ifb.btn_up = up; ifb.btn_dn = dn; ifb.confirm = cf; ifb.unlock = ul;
        end
        tick();
        if (d == 0) begin
            ifa.btn_up = 0; ifa.btn_dn = 0; ifa.confirm = 0; ifa.unlock = 0;
        end else begin
            ifb.btn_up = 0; ifb.btn_dn = 0; ifb.confirm = 0; ifb.unlock = 0;
        end
    endtask

    initial begin
        string sweep_a;
        string expert;
        int    n_e;
        int    n_blank;
        sweep_a = "   DIFFICULTY:        EASY      ";
        expert  = "EXPERT";
        checks = 0;
        errors = 0;
        model_valid = 1'b0;
        reset = 1'b1;
        ifa.char_xy = 8'h00; ifa.btn_up = 0; ifa.btn_dn = 0; ifa.confirm = 0; ifa.unlock = 0;
        ifb.char_xy = 8'h00; ifb.btn_up = 0; ifb.btn_dn = 0; ifb.confirm = 0; ifb.unlock = 0;
        tick();
        tick();
        checkOutput("reset_code",   int'(ifa.char_code), 'h20);
        checkOutput("reset_level",  int'(ifa.level), 0);
        checkOutput("reset_locked", int'(ifa.locked), 0);
        reset = 1'b0;

        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("confirm_locked", int'(ifa.locked), 1);
        for (int i = 0; i < 32; i++) begin
            setXy(0, 8'(i));
            tick();
            checkOutput($sformatf("sweep_%02h", i), int'(ifa.char_code), int'(sweep_a[i]));
        end

        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("unlock_locked", int'(ifa.locked), 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("wrap_dn", int'(ifa.level), 2);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("up_twice", int'(ifa.level), 1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("up_dn_hold", int'(ifa.level), 1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("back_to_0", int'(ifa.level), 0);

        setXy(0, 8'h16);
        tick();
        n_e = 0;
        n_blank = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (ifa.char_code == 7'h45) n_e++;
            if (ifa.char_code == 7'h20) n_blank++;
        end
        checkOutput("blink_e_count", n_e, 8);
        checkOutput("blink_blank_count", n_blank, 8);

        applyStimulus(0, 0, 0, 1, 0);
        n_e = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (ifa.char_code == 7'h45) n_e++;
        end
        checkOutput("locked_steady", n_e, 16);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("confirm_up_level", int'(ifa.level), 1);
        checkOutput("confirm_up_locked", int'(ifa.locked), 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("locked_ignores_up", int'(ifa.level), 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("unlock_again", int'(ifa.locked), 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("up_after_unlock", int'(ifa.level), 2);
        applyStimulus(0, 0, 0, 1, 0);

        reset = 1'b1;
        ifa.btn_up = 1'b1;
        tick();
        checkOutput("midreset_level", int'(ifa.level), 0);
        checkOutput("midreset_locked", int'(ifa.locked), 0);
        checkOutput("midreset_code", int'(ifa.char_code), 'h20);
        reset = 1'b0;
        ifa.btn_up = 1'b0;
        tick();
        checkOutput("after_reset_level", int'(ifa.level), 0);

        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("b_wrap_dn", int'(ifb.level), 3);
        applyStimulus(1, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            setXy(1, 8'(8'h15 + i));
            tick();
            checkOutput($sformatf("expert_%0d", i), int'(ifb.char_code), int'(expert[i]));
        end
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("b_wrap_up", int'(ifb.level), 0);
        setXy(1, 8'h25);
        tick();
        checkOutput("b_out_of_range", int'(ifb.char_code), 'h20);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
